instr_fetch_stage: RTL and testbench
====================================

INSTR_FETCH_STAGE -- requirements
Module: instr_fetch_stage

Interface
REQ-001 SHALL have parameters: PC_ADDR, 32'h8000_0000, reset PC; ADDR_WIDTH, 32, address width; DATA_WIDTH, 32, instruction width.
REQ-002 SHALL have one clock and an asynchronous, active-high reset: clk_i  in  1  clock; rst_i  in  1  async reset, active-high.
REQ-003 SHALL have stall_and_flush  in  2  from hazard unit; bit1 = stall, bit0 = flush.
REQ-004 SHALL have redirect_i  in  1  one-cycle branch/jump taken pulse, and redirect_pc_i  in  ADDR_WIDTH  target.
REQ-005 SHALL have Wishbone master ports: wb_cyc_o, wb_stb_o  out  1; wb_adr_o  out  ADDR_WIDTH; wb_sel_o  out  4; wb_we_o  out  1; wb_dat_i  in  DATA_WIDTH; wb_ack_i  in  1.
REQ-006 SHALL have IF/ID outputs: IFID_pc_o  out  ADDR_WIDTH; IFID_inst_o  out  DATA_WIDTH; IFID_valid_o  out  1; IFID_rs1_addr_o, IFID_rs2_addr_o  out  5, equal to IFID_inst_o[19:15] and [24:20].

Function
REQ-007 SHALL keep fetch PC register pc; wb_adr_o = pc during a fetch; wb_sel_o = 4'b1111 and wb_we_o = 0 always.
REQ-008 SHALL implement FSM states IDLE, FETCH, HOLD; all Wishbone outputs registered.
REQ-009 IDLE: if stall = 0, assert wb_cyc_o = wb_stb_o = 1 at the next edge, go to FETCH; if stall = 1, remain IDLE.
REQ-010 FETCH: hold cyc/stb/adr stable until wb_ack_i; deassert cyc/stb at the edge sampling ack.
REQ-011 On ack with no pending redirect and stall = 0: load IF/ID with {pc, wb_dat_i, valid = 1}, pc <= pc + 4, go IDLE.
REQ-012 On ack with no pending redirect and stall = 1: capture wb_dat_i into hold buffer, go HOLD.
REQ-013 HOLD: when stall = 0, load IF/ID from hold buffer with valid = 1, pc <= pc + 4, go IDLE.
REQ-014 Every edge with stall = 0 and no instruction delivered, IF/ID SHALL load a bubble: inst = NOP (32'h0000_0013), valid = 0, pc unchanged.
REQ-015 stall = 1 and flush = 0: IF/ID outputs SHALL hold value.
REQ-016 flush = 1 (priority over stall): IF/ID SHALL load bubble at the next edge.
REQ-017 redirect_i in IDLE or HOLD: pc <= redirect_pc_i, hold buffer discarded, state IDLE.
REQ-018 redirect_i in FETCH: latch target and set discard flag; transaction runs to ack; data dropped; pc <= latched target; go IDLE; flag cleared.
REQ-019 Second redirect_i while discard flag set SHALL overwrite latched target.
REQ-020 redirect_pc_i with [1:0] != 0 SHALL be used with bits [1:0] forced to 0.
REQ-021 pc + 4 SHALL wrap modulo 2^ADDR_WIDTH.

Reset
REQ-022 While rst_i = 1: pc = PC_ADDR, state IDLE, wb_cyc_o = wb_stb_o = 0, wb_adr_o = PC_ADDR, IFID_inst_o = NOP, IFID_valid_o = 0, IFID_pc_o = 0, discard flag 0.
REQ-023 Reset asserted mid-FETCH SHALL drop cyc/stb immediately (async); a late ack after reset SHALL be ignored in IDLE.

Structure
REQ-024 Package pipeline_pkg SHALL hold NOP constant, fetch_state_t enum, STALL_BIT = 1, FLUSH_BIT = 0.
REQ-025 IF/ID register SHALL be one sub-module ifid_reg (load/hold/bubble control); remainder in instr_fetch_stage.

Verification
REQ-026 Reset release, ack 1 cycle after stb, no stall -> fetches at 8000_0000, 8000_0004, 8000_0008 in order; IFID_valid_o pulses with matching pc/inst.
REQ-027 stall_and_flush = 2'b10 for 3 cycles during ack at 8000_0004 -> IF/ID holds prior instruction; after release, 8000_0004 inst delivered once, none lost or duplicated.
REQ-028 redirect_i to 8000_0100 while FETCH at 8000_0008 pending (ack 2 cycles later) -> 8000_0008 data never reaches IF/ID; next wb_adr_o = 8000_0100.
REQ-029 stall_and_flush = 2'b11 -> IF/ID becomes NOP, valid 0 next edge.
REQ-030 rst_i pulse mid-FETCH, then stray ack -> cyc/stb low immediately; no IF/ID load; refetch from 8000_0000.
REQ-031 IF/ID inst 32'h0020_81B3 (add x3,x1,x2) -> IFID_rs1_addr_o = 1, IFID_rs2_addr_o = 2.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared fetch-stage definitions: NOP encoding, FSM state type and hazard-bus bit positions.
package pipeline_pkg;

  localparam logic [31:0] NOP = 32'h0000_0013;

  localparam int unsigned STALL_BIT = 1;
  localparam int unsigned FLUSH_BIT = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_stage_if.sv
// Wishbone classic instruction bus between the fetch stage (master) and memory (slave).
interface instr_fetch_stage_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) ();

  logic                  wb_cyc_o;
  logic                  wb_stb_o;
  logic [ADDR_WIDTH-1:0] wb_adr_o;
  logic [3:0]            wb_sel_o;
  logic                  wb_we_o;
  logic [DATA_WIDTH-1:0] wb_dat_i;
  logic                  wb_ack_i;

  modport master (
    output wb_cyc_o, wb_stb_o, wb_adr_o, wb_sel_o, wb_we_o,
    input  wb_dat_i, wb_ack_i
  );

  modport slave (
    input  wb_cyc_o, wb_stb_o, wb_adr_o, wb_sel_o, wb_we_o,
    output wb_dat_i, wb_ack_i
  );

endinterface

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: flush forces a bubble, stall holds, otherwise load or bubble.
module ifid_reg
  import pipeline_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  stall_i,
  input  logic                  load_i,
  input  logic [ADDR_WIDTH-1:0] pc_i,
  input  logic [DATA_WIDTH-1:0] inst_i,
  output logic [ADDR_WIDTH-1:0] pc_o,
  output logic [DATA_WIDTH-1:0] inst_o,
  output logic                  valid_o
);

  logic [ADDR_WIDTH-1:0] pc_q;
  logic [DATA_WIDTH-1:0] inst_q;
  logic                  valid_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q    <= '0;
      inst_q  <= DATA_WIDTH'(NOP);
      valid_q <= 1'b0;
    end else if (flush_i) begin
      inst_q  <= DATA_WIDTH'(NOP);
      valid_q <= 1'b0;
    end else if (!stall_i) begin
      if (load_i) begin
        pc_q    <= pc_i;
        inst_q  <= inst_i;
        valid_q <= 1'b1;
      end else begin
        // Bubble keeps the last pc so downstream debug still sees where IF was.
        inst_q  <= DATA_WIDTH'(NOP);
        valid_q <= 1'b0;
      end
    end
  end

  assign pc_o    = pc_q;
  assign inst_o  = inst_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/instr_fetch_stage.sv
// Instruction fetch: one Wishbone read per instruction, hold buffer for stalls,
// redirect handling that lets an in-flight read finish and drops its data.
module instr_fetch_stage
  import pipeline_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] PC_ADDR    = 32'h8000_0000
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [1:0]             stall_and_flush,
  input  logic                   redirect_i,
  input  logic [ADDR_WIDTH-1:0]  redirect_pc_i,
  instr_fetch_stage_if.master    wb,
  output logic [ADDR_WIDTH-1:0]  IFID_pc_o,
  output logic [DATA_WIDTH-1:0]  IFID_inst_o,
  output logic                   IFID_valid_o,
  output logic [4:0]             IFID_rs1_addr_o,
  output logic [4:0]             IFID_rs2_addr_o
);

  fetch_state_t          state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic                  discard_q, discard_d;
  logic [ADDR_WIDTH-1:0] target_q, target_d;
  logic                  cyc_q, cyc_d;
  logic [ADDR_WIDTH-1:0] adr_q, adr_d;

  logic                  stall, flush, deliver, load;
  logic [DATA_WIDTH-1:0] load_inst;
  logic [ADDR_WIDTH-1:0] redirect_tgt;

  assign stall        = stall_and_flush[STALL_BIT];
  assign flush        = stall_and_flush[FLUSH_BIT];
  assign deliver      = !stall && !flush;
  assign redirect_tgt = {redirect_pc_i[ADDR_WIDTH-1:2], 2'b00};

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    hold_d    = hold_q;
    discard_d = discard_q;
    target_d  = target_q;
    cyc_d     = cyc_q;
    adr_d     = adr_q;
    load      = 1'b0;
    load_inst = wb.wb_dat_i;

    unique case (state_q)
      IDLE: begin
        if (redirect_i) begin
          pc_d = redirect_tgt;
        end else if (!stall) begin
          cyc_d   = 1'b1;
          adr_d   = pc_q;
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (redirect_i) begin
          target_d  = redirect_tgt;
          discard_d = 1'b1;
        end
        if (wb.wb_ack_i) begin
          cyc_d = 1'b0;
          if (discard_q || redirect_i) begin
            // A redirect on the ack edge itself still wins over the stale data.
            pc_d      = redirect_i ? redirect_tgt : target_q;
            discard_d = 1'b0;
            state_d   = IDLE;
          end else if (deliver) begin
            load    = 1'b1;
            pc_d    = pc_q + ADDR_WIDTH'(4);
            state_d = IDLE;
          end else begin
            hold_d  = wb.wb_dat_i;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (redirect_i) begin
          pc_d    = redirect_tgt;
          state_d = IDLE;
        end else if (deliver) begin
          load      = 1'b1;
          load_inst = hold_q;
          pc_d      = pc_q + ADDR_WIDTH'(4);
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      pc_q      <= PC_ADDR;
      hold_q    <= '0;
      discard_q <= 1'b0;
      target_q  <= '0;
      cyc_q     <= 1'b0;
      adr_q     <= PC_ADDR;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      hold_q    <= hold_d;
      discard_q <= discard_d;
      target_q  <= target_d;
      cyc_q     <= cyc_d;
      adr_q     <= adr_d;
    end
  end

  assign wb.wb_cyc_o = cyc_q;
  assign wb.wb_stb_o = cyc_q;
  assign wb.wb_adr_o = adr_q;
  assign wb.wb_sel_o = 4'b1111;
  assign wb.wb_we_o  = 1'b0;

  ifid_reg #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_ifid_reg (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (flush),
    .stall_i (stall),
    .load_i  (load),
    .pc_i    (pc_q),
    .inst_i  (load_inst),
    .pc_o    (IFID_pc_o),
    .inst_o  (IFID_inst_o),
    .valid_o (IFID_valid_o)
  );

  assign IFID_rs1_addr_o = IFID_inst_o[19:15];
  assign IFID_rs2_addr_o = IFID_inst_o[24:20];

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Randomized bench: memory responder + stimulus push expected deliveries into a
// scoreboard; an independent monitor checks every IF/ID update against it.
module tb_instr_fetch_stage;
  import pipeline_pkg::*;

  localparam logic [31:0] PC0 = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  sf;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] ifid_pc, ifid_inst;
  logic        ifid_valid;
  logic [4:0]  rs1, rs2;

  instr_fetch_stage_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) wb ();

  instr_fetch_stage #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .PC_ADDR   (PC0)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .stall_and_flush (sf),
    .redirect_i      (redirect),
    .redirect_pc_i   (redirect_pc),
    .wb              (wb),
    .IFID_pc_o       (ifid_pc),
    .IFID_inst_o     (ifid_inst),
    .IFID_valid_o    (ifid_valid),
    .IFID_rs1_addr_o (rs1),
    .IFID_rs2_addr_o (rs2)
  );

  always #5 clk = ~clk;

  // Memory contents: injective per word address; the reset vector holds add x3,x1,x2.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == PC0) return 32'h0020_81B3;
    return {a[15:0] ^ 16'hC3A5, a[31:16] ^ 16'h1F0F};
  endfunction

  assign wb.wb_dat_i = mem_word(wb.wb_adr_o);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_miss = 0;
  bit   mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: IF/ID behaviour depends only on the hazard bits seen at the edge.
  logic [31:0] prev_pc = '0;
  logic [31:0] prev_inst = NOP;
  logic        prev_valid = 1'b0;

  always begin : mon
    logic [1:0] sf_e;
    logic       rst_e;
    exp_t       e;
    @(posedge clk);
    sf_e  = sf;
    rst_e = rst;
    #1;
    if (mon_en && !rst_e && !rst) begin
      if (sf_e[FLUSH_BIT]) begin
        check("flush_valid", {31'b0, ifid_valid}, 32'd0);
        check("flush_inst", ifid_inst, NOP);
      end else if (sf_e[STALL_BIT]) begin
        check("stall_hold_pc", ifid_pc, prev_pc);
        check("stall_hold_inst", ifid_inst, prev_inst);
        check("stall_hold_valid", {31'b0, ifid_valid}, {31'b0, prev_valid});
      end else if (ifid_valid) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL unexpected_delivery: got pc %h, expected no delivery", ifid_pc);
        end else begin
          e = sb.pop_front();
          check("deliver_pc", ifid_pc, e.pc);
          check("deliver_inst", ifid_inst, e.inst);
          check("rs1", {27'b0, rs1}, {27'b0, e.inst[19:15]});
          check("rs2", {27'b0, rs2}, {27'b0, e.inst[24:20]});
        end
      end else begin
        check("bubble_inst", ifid_inst, NOP);
        check("bubble_pc", ifid_pc, prev_pc);
      end
    end
    prev_pc    = ifid_pc;
    prev_inst  = ifid_inst;
    prev_valid = ifid_valid;
  end

  // Reference: next fetch address in program order, redirect target pending on a read.
  logic [31:0] model_pc;
  logic [31:0] txn_adr;
  logic [31:0] redir_tgt;
  bit          in_txn;
  bit          redir_pend;
  int          lat;
  int          max_lat;

  task automatic stim(input int p_stall, input int p_flush, input int p_redir);
    logic [31:0] tgt;
    @(negedge clk);
    wb.wb_ack_i = 1'b0;
    redirect    = 1'b0;
    sf = {($urandom_range(99) < p_stall), ($urandom_range(99) < p_flush)};
    if (wb.wb_cyc_o && !in_txn) begin
      check("fetch_adr", wb.wb_adr_o, model_pc);
      check("sel_we", {27'b0, wb.wb_sel_o, wb.wb_we_o}, 32'h1E);
      in_txn  = 1'b1;
      txn_adr = wb.wb_adr_o;
      lat     = $urandom_range(max_lat);
    end
    if (in_txn) begin
      check("adr_stable", wb.wb_adr_o, txn_adr);
      check("stb_cyc", {30'b0, wb.wb_stb_o, wb.wb_cyc_o}, 32'h3);
    end
    if ($urandom_range(99) < p_redir) begin
      tgt = ($urandom_range(7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15)))
                                     : (PC0 | ($urandom & 32'h0000_0FFF));
      redirect    = 1'b1;
      redirect_pc = tgt;
      tgt[1:0]    = 2'b00;
      if (in_txn) begin
        redir_pend = 1'b1;
        redir_tgt  = tgt;
      end else begin
        // With no read open, a queued entry can only be the one parked in the hold buffer.
        if (sb.size() != 0) void'(sb.pop_back());
        model_pc = tgt;
      end
    end
    if (in_txn) begin
      if (lat == 0) begin
        wb.wb_ack_i = 1'b1;
        if (redir_pend) begin
          model_pc   = redir_tgt;
          redir_pend = 1'b0;
        end else begin
          sb.push_back(exp_t'{pc: txn_adr, inst: mem_word(txn_adr)});
          model_pc = model_pc + 32'd4;
        end
        in_txn = 1'b0;
      end else begin
        lat--;
      end
    end
  endtask

  initial begin
    int k;
    rst         = 1'b1;
    sf          = 2'b10;
    redirect    = 1'b0;
    redirect_pc = '0;
    wb.wb_ack_i = 1'b0;
    in_txn      = 1'b0;
    redir_pend  = 1'b0;
    lat         = 0;
    max_lat     = 0;
    model_pc    = PC0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_cyc", {31'b0, wb.wb_cyc_o}, 32'd0);
    check("rst_stb", {31'b0, wb.wb_stb_o}, 32'd0);
    check("rst_adr", wb.wb_adr_o, PC0);
    check("rst_inst", ifid_inst, NOP);
    check("rst_valid", {31'b0, ifid_valid}, 32'd0);
    check("rst_pc", ifid_pc, 32'd0);

    @(negedge clk);
    rst    = 1'b0;
    mon_en = 1'b1;

    // Back-to-back fetches with single-cycle ack and no hazards.
    repeat (12) stim(0, 0, 0);

    max_lat = 3;
    repeat (3000) stim(25, 5, 8);

    for (k = 0; k < 60 && (sb.size() != 0 || redir_pend); k++) stim(0, 0, 0);
    check("drain_empty", 32'(sb.size()) + 32'(redir_pend), 32'd0);

    // Reset in the middle of an open read, then a stray ack.
    for (k = 0; k < 40 && !(in_txn && lat > 0); k++) stim(0, 0, 0);
    check("rst_mid_fetch_open", {31'b0, in_txn}, 32'd1);
    mon_en = 1'b0;
    sf     = 2'b10;
    rst    = 1'b1;
    #1;
    check("async_rst_cyc", {31'b0, wb.wb_cyc_o}, 32'd0);
    check("async_rst_stb", {31'b0, wb.wb_stb_o}, 32'd0);
    @(negedge clk);
    rst         = 1'b0;
    wb.wb_ack_i = 1'b1;
    @(negedge clk);
    wb.wb_ack_i = 1'b0;
    check("stray_ack_valid", {31'b0, ifid_valid}, 32'd0);
    check("stray_ack_cyc", {31'b0, wb.wb_cyc_o}, 32'd0);
    model_pc   = PC0;
    in_txn     = 1'b0;
    redir_pend = 1'b0;
    lat        = 0;
    max_lat    = 0;
    sb.delete();
    mon_en = 1'b1;
    repeat (8) stim(0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
